// File: rtl/hsv_mask_pkg.sv
// Shared constants for the HSV mask filter: default widths, cfg_addr map, reset thresholds.
// No logic; thr_default rescales the Q16.15 reset constants to an instance's FRAC.
package hsv_mask_pkg;

    localparam int N_DEF    = 32;
    localparam int FRAC_DEF = 15;

    localparam logic [2:0] ADDR_H_LO = 3'd0;
    localparam logic [2:0] ADDR_H_HI = 3'd1;
    localparam logic [2:0] ADDR_S_LO = 3'd2;
    localparam logic [2:0] ADDR_S_HI = 3'd3;
    localparam logic [2:0] ADDR_V_LO = 3'd4;
    localparam logic [2:0] ADDR_V_HI = 3'd5;

    localparam logic [31:0] H_MAX = 32'h00B4_0000;
    localparam logic [31:0] S_ONE = 32'h0000_8000;
    localparam logic [31:0] V_MAX = 32'h007F_8000;

    // Lower bounds reset to 0, upper bounds to the full channel range.
    function automatic logic [31:0] thr_default(input logic [2:0] addr, input int frac);
        logic [31:0] val;
        case (addr)
            ADDR_H_HI: val = (H_MAX >> FRAC_DEF) << frac;
            ADDR_S_HI: val = (S_ONE >> FRAC_DEF) << frac;
            ADDR_V_HI: val = (V_MAX >> FRAC_DEF) << frac;
            default:   val = 32'h0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/hsv_range_cmp.sv
// Inclusive window test on the magnitude of a sign-magnitude word; WRAP_EN allows lo > hi wrap.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module hsv_range_cmp #(
    parameter int N       = 32,
    parameter bit WRAP_EN = 1'b0
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    output logic         pass
);

    logic [N-2:0] x_mag, lo_mag, hi_mag;
    logic         ge_lo, le_hi, in_win;
    // Threshold sign bits take no part in the comparison.
    logic         unused_thr_sign;

    assign x_mag  = x[N-2:0];
    assign lo_mag = lo[N-2:0];
    assign hi_mag = hi[N-2:0];
    assign unused_thr_sign = lo[N-1] ^ hi[N-1];

    always_comb begin
        ge_lo  = (x_mag >= lo_mag);
        le_hi  = (x_mag <= hi_mag);
        in_win = 1'b0;
        if (lo_mag <= hi_mag) begin
            in_win = ge_lo & le_hi;
        end else if (WRAP_EN) begin
            in_win = ge_lo | le_hi;
        end
        pass = ~x[N-1] & in_win;
    end

endmodule

// File: rtl/hsv_mask_filter.sv
// HSV window mask with frame-synchronous threshold commit; optional per-frame hit counter (HSV_MASK_COUNT_EN).
// Latency: 2 cycles input-to-output, 1 pixel/cycle.
// Backpressure: whole pipe stalls when S2 is full and out_ready=0; in_ready = out_ready | ~out_valid.
module hsv_mask_filter
    import hsv_mask_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_h,
    input  logic [N-1:0] in_s,
    input  logic [N-1:0] in_v,
    input  logic         in_sof,
    input  logic         in_eof,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_mask,
    output logic         out_sof,
    output logic         out_eof,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [N-1:0] cfg_data,
    output logic [N-1:0] hit_count,
    output logic         count_valid
);

    localparam int NREG = 6;

    logic [NREG-1:0][N-1:0] shadow_q, shadow_d, active_q, thr_eff;
    logic adv, acc, commit;
    logic pass_h, pass_s, pass_v;
    logic s1_vld, s1_ph, s1_ps, s1_pv, s1_sof, s1_eof;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign acc      = in_valid & adv;
    assign commit   = acc & in_sof;

    // The sof pixel compares against the set it commits, including a same-cycle cfg write.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            for (int i = 0; i < NREG; i++) begin
                if (cfg_addr == 3'(i)) shadow_d[i] = cfg_data;
            end
        end
        thr_eff = commit ? shadow_d : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= N'(thr_default(3'(i), FRAC));
                active_q[i] <= N'(thr_default(3'(i), FRAC));
            end
        end else begin
            shadow_q <= shadow_d;
            if (commit) active_q <= shadow_d;
        end
    end

    hsv_range_cmp #(.N(N), .WRAP_EN(1'b1)) u_cmp_h (
        .x(in_h), .lo(thr_eff[ADDR_H_LO]), .hi(thr_eff[ADDR_H_HI]), .pass(pass_h)
    );
    hsv_range_cmp #(.N(N), .WRAP_EN(1'b0)) u_cmp_s (
        .x(in_s), .lo(thr_eff[ADDR_S_LO]), .hi(thr_eff[ADDR_S_HI]), .pass(pass_s)
    );
    hsv_range_cmp #(.N(N), .WRAP_EN(1'b0)) u_cmp_v (
        .x(in_v), .lo(thr_eff[ADDR_V_LO]), .hi(thr_eff[ADDR_V_HI]), .pass(pass_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_ph     <= 1'b0;
            s1_ps     <= 1'b0;
            s1_pv     <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            out_valid <= 1'b0;
            out_mask  <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (adv) begin
            s1_vld    <= in_valid;
            s1_ph     <= pass_h;
            s1_ps     <= pass_s;
            s1_pv     <= pass_v;
            s1_sof    <= in_sof & in_valid;
            s1_eof    <= in_eof & in_valid;
            out_valid <= s1_vld;
            out_mask  <= s1_vld & s1_ph & s1_ps & s1_pv;
            out_sof   <= s1_sof;
            out_eof   <= s1_eof;
        end
    end

`ifdef HSV_MASK_COUNT_EN
    logic [N-1:0] cnt_q, cnt_nxt;
    logic         handoff;

    assign handoff = out_valid & out_ready;

    // An sof pixel restarts the count, dropping any unterminated partial frame.
    always_comb begin
        cnt_nxt = out_sof ? '0 : cnt_q;
        if (out_mask && (cnt_nxt != '1)) cnt_nxt = cnt_nxt + N'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hit_count   <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (handoff) begin
                cnt_q <= cnt_nxt;
                if (out_eof) begin
                    hit_count   <= cnt_nxt;
                    count_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign hit_count   = '0;
    assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hsv_mask_filter.sv
// Directed bench for hsv_mask_filter: vector table for window checks plus hand sequences
// for threshold commit, backpressure, hit counter and mid-frame reset.
module tb_hsv_mask_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sof, in_eof;
    logic [31:0] in_h, in_s, in_v;
    logic        out_valid, out_ready, out_mask, out_sof, out_eof;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] hit_count;
    logic        count_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hsv_mask_filter dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_h(in_h), .in_s(in_s), .in_v(in_v),
        .in_sof(in_sof), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_sof(out_sof), .out_eof(out_eof),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .hit_count(hit_count), .count_valid(count_valid)
    );

    typedef struct {
        logic [31:0] h;
        logic [31:0] s;
        logic [31:0] v;
        logic        sof;
        logic        eof;
        logic        exp;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One isolated pixel: out_valid must be low one cycle later and high with the mask two cycles later.
    task automatic send_one(input logic [31:0] h, s, v, input logic sof, eof, exp, input string name);
        in_h = h; in_s = s; in_v = v; in_sof = sof; in_eof = eof; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; cfg_we = 1'b0;
        check({name, " lat1"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check({name, " vld"}, out_valid, 1'b1);
        check({name, " mask"}, out_mask, exp);
    endtask

    localparam logic [31:0] H10  = 32'h0005_0000;
    localparam logic [31:0] H20  = 32'h000A_0000;
    localparam logic [31:0] H30  = 32'h000F_0000;
    localparam logic [31:0] SHLF = 32'h0000_4000;
    localparam logic [31:0] V128 = 32'h0040_0000;

    initial begin
        logic [7:0] bp_mask;
        int sent, got;
        logic stall_prev, hm, he, hs;

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_h = '0; in_s = '0; in_v = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

        tbl[0]  = '{H10,          SHLF,          V128,          1'b1, 1'b0, 1'b1};
        tbl[1]  = '{32'h00B18000, SHLF,          V128,          1'b0, 1'b0, 1'b1};
        tbl[2]  = '{H30,          SHLF,          V128,          1'b0, 1'b0, 1'b0};
        tbl[3]  = '{H20,          SHLF,          V128,          1'b0, 1'b0, 1'b1};
        tbl[4]  = '{32'h000A0001, SHLF,          V128,          1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h00AF0000, SHLF,          V128,          1'b0, 1'b0, 1'b1};
        tbl[6]  = '{32'h00AE8000, SHLF,          V128,          1'b0, 1'b0, 1'b0};
        tbl[7]  = '{H10,          32'h80004000,  V128,          1'b0, 1'b0, 1'b0};
        tbl[8]  = '{H10,          32'h00008000,  32'h007F8000,  1'b0, 1'b0, 1'b1};
        tbl[9]  = '{H10,          32'h00008001,  V128,          1'b0, 1'b0, 1'b0};
        tbl[10] = '{H10,          SHLF,          32'h007F8001,  1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'h80050000, SHLF,          V128,          1'b0, 1'b0, 1'b0};
        tbl[12] = '{32'h00000000, SHLF,          V128,          1'b0, 1'b1, 1'b1};

        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_mask", out_mask, 1'b0);
        check("rst out_sof", out_sof, 1'b0);
        check("rst out_eof", out_eof, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst hit_count", hit_count, 32'h0);
        check("rst count_valid", count_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send_one(H30, SHLF, V128, 1'b1, 1'b0, 1'b1, "default");

        // Hue window 350..20, committed by the first table pixel's sof.
        cfg_write(3'd0, 32'h00AF0000);
        cfg_write(3'd1, H20);
        for (int i = 0; i < 13; i++) begin
            send_one(tbl[i].h, tbl[i].s, tbl[i].v, tbl[i].sof, tbl[i].eof, tbl[i].exp,
                     $sformatf("tbl%0d", i));
        end

        // Shadow write mid-frame stays invisible until the next sof.
        send_one(H10, SHLF, V128, 1'b1, 1'b0, 1'b1, "commit sof");
        cfg_write(3'd4, 32'h00640000);
        send_one(H10, SHLF, V128, 1'b0, 1'b0, 1'b1, "commit hold");
        send_one(H10, SHLF, V128, 1'b1, 1'b0, 1'b0, "commit new");
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 32'h0;
        send_one(H10, SHLF, V128, 1'b1, 1'b0, 1'b1, "write-through");
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 32'hFFFF_FFFF;
        send_one(H10, SHLF, V128, 1'b1, 1'b0, 1'b1, "addr6 ignored");

        // Hit counter: masks 1,0,1,1,0 then a one-pixel frame.
        send_one(H10, SHLF, V128, 1'b1, 1'b0, 1'b1, "cnt p0");
        send_one(H30, SHLF, V128, 1'b0, 1'b0, 1'b0, "cnt p1");
        send_one(H10, SHLF, V128, 1'b0, 1'b0, 1'b1, "cnt p2");
        send_one(H10, SHLF, V128, 1'b0, 1'b0, 1'b1, "cnt p3");
        send_one(H30, SHLF, V128, 1'b0, 1'b1, 1'b0, "cnt p4");
        check("cnt pulse early", count_valid, 1'b0);
        @(posedge clk); #1;
`ifdef HSV_MASK_COUNT_EN
        check("cnt pulse", count_valid, 1'b1);
        check("cnt value 3", hit_count, 32'd3);
`else
        check("cnt pulse off", count_valid, 1'b0);
        check("cnt value off", hit_count, 32'd0);
`endif
        @(posedge clk); #1;
        check("cnt pulse single", count_valid, 1'b0);
        send_one(H10, SHLF, V128, 1'b1, 1'b1, 1'b1, "cnt 1px");
        @(posedge clk); #1;
`ifdef HSV_MASK_COUNT_EN
        check("cnt 1px pulse", count_valid, 1'b1);
        check("cnt value 1", hit_count, 32'd1);
`else
        check("cnt 1px off", hit_count, 32'd0);
`endif

        // Backpressure: 8 pixels, out_ready pattern 1,0,0,1 repeating.
        bp_mask = 8'b0100_1101;
        sent = 0; got = 0; stall_prev = 1'b0; hm = 1'b0; he = 1'b0; hs = 1'b0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_h = bp_mask[sent] ? H20 : H30;
                in_s = SHLF; in_v = V128;
                in_sof = (sent == 0); in_eof = (sent == 7);
            end else begin
                in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
            end
            #1;
            if (stall_prev) begin
                check("bp hold vld", out_valid, 1'b1);
                check("bp hold mask", out_mask, hm);
                check("bp hold sof", out_sof, hs);
                check("bp hold eof", out_eof, he);
            end
            check("bp in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                check($sformatf("bp mask%0d", got), out_mask, bp_mask[got]);
                check($sformatf("bp sof%0d", got), out_sof, got == 0);
                check($sformatf("bp eof%0d", got), out_eof, got == 7);
                got++;
            end
            stall_prev = out_valid && !out_ready;
            hm = out_mask; he = out_eof; hs = out_sof;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; out_ready = 1'b1;
        check("bp out count", got, 8);
        check("bp in count", sent, 8);
        @(posedge clk); #1;
        check("bp drained", out_valid, 1'b0);

        // Reset with a pixel in flight: pixel dropped, thresholds back to defaults.
        in_h = H10; in_s = SHLF; in_v = V128; in_sof = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst out_valid", out_valid, 1'b0);
        check("mrst in_ready", in_ready, 1'b1);
        check("mrst hit_count", hit_count, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst dropped", out_valid, 1'b0);
        send_one(H30, SHLF, V128, 1'b1, 1'b0, 1'b1, "mrst thr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
